key_event_ctrl: RTL and testbench

Sequencer that sits behind the key debouncer and turns its debounced key levels into classified key events for the menu/control logic. Only one key is tracked at a time. A key is reported as a short press, a long press, or an auto-repeat. Events are handed to the consumer through a single-entry valid/ready register, and events that cannot be accepted are flagged as overflow.

---
 rtl/key_evt_pkg.sv | 15 +
 rtl/ms_tick_gen.sv | 20 ++
 rtl/key_event_ctrl.sv | 141 ++++++++++++++
 tb/tb_key_event_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared encodings for the key event sequencer: event type codes and FSM states.
package key_evt_pkg;

  localparam logic [1:0] EVT_SHORT  = 2'd1;
  localparam logic [1:0] EVT_LONG   = 2'd2;
  localparam logic [1:0] EVT_REPEAT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HELD     = 2'd1,
    ST_LONG     = 2'd2,
    ST_WAIT_ALL = 2'd3
  } key_state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running divider; tick pulses for one clk when the count reaches CLK_DIV-1.
module ms_tick_gen #(
  parameter int CLK_DIV = 24000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/key_event_ctrl.sv
// Tracks one debounced key at a time and classifies it as SHORT, LONG or REPEAT,
// handing events out through a single-entry valid/ready register with sticky overflow.
module key_event_ctrl
  import key_evt_pkg::*;
#(
  parameter int N       = 2,
  parameter int CLK_DIV = 24000,
  parameter int LONG_MS = 1000,
  parameter int REP_MS  = 200,
  localparam int KW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  key_n,
  input  logic          evt_ready,
  output logic          evt_valid,
  output logic [KW-1:0] evt_key,
  output logic [1:0]    evt_type,
  output logic          evt_ovf,
  output logic          busy
);
  localparam int HW = $clog2(LONG_MS);
  localparam int RW = $clog2(REP_MS);

  key_state_t    state, state_nxt;
  logic [KW-1:0] cur_key, low_key;
  logic [HW-1:0] hold_ms;
  logic [RW-1:0] rep_ms;
  logic          tick, any_pressed, cur_rel;
  logic          capture, hold_clr, hold_inc, rep_clr, rep_inc, emit;
  logic [1:0]    emit_type;

  ms_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Lowest index wins when several keys go down together
  always_comb begin
    low_key = '0;
    for (int i = N - 1; i >= 0; i--)
      if (!key_n[i]) low_key = KW'(i);
  end

  assign any_pressed = ~&key_n;
  assign cur_rel     = key_n[cur_key];
  assign busy        = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    hold_clr  = 1'b0;
    hold_inc  = 1'b0;
    rep_clr   = 1'b0;
    rep_inc   = 1'b0;
    emit      = 1'b0;
    emit_type = EVT_SHORT;
    case (state)
      ST_IDLE: begin
        if (any_pressed) begin
          capture   = 1'b1;
          hold_clr  = 1'b1;
          state_nxt = ST_HELD;
        end
      end
      ST_HELD: begin
        // Release outranks a tick landing in the same cycle
        if (cur_rel) begin
          emit      = 1'b1;
          emit_type = EVT_SHORT;
          state_nxt = ST_WAIT_ALL;
        end else if (tick) begin
          if (hold_ms == HW'(LONG_MS - 1)) begin
            emit      = 1'b1;
            emit_type = EVT_LONG;
            hold_clr  = 1'b1;
            rep_clr   = 1'b1;
            state_nxt = ST_LONG;
          end else begin
            hold_inc = 1'b1;
          end
        end
      end
      ST_LONG: begin
        if (cur_rel) begin
          state_nxt = ST_WAIT_ALL;
        end else if (tick) begin
          if (rep_ms == RW'(REP_MS - 1)) begin
            emit      = 1'b1;
            emit_type = EVT_REPEAT;
            rep_clr   = 1'b1;
          end else begin
            rep_inc = 1'b1;
          end
        end
      end
      ST_WAIT_ALL: begin
        // Chorded keys are swallowed until everything is up
        if (&key_n) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cur_key <= '0;
      hold_ms <= '0;
      rep_ms  <= '0;
    end else begin
      state <= state_nxt;
      if (capture) cur_key <= low_key;
      if (hold_clr)      hold_ms <= '0;
      else if (hold_inc) hold_ms <= hold_ms + HW'(1);
      if (rep_clr)       rep_ms <= '0;
      else if (rep_inc)  rep_ms <= rep_ms + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_type  <= 2'd0;
      evt_ovf   <= 1'b0;
    end else if (emit) begin
      // A same-cycle transfer frees the slot for the new event
      if (!evt_valid || evt_ready) begin
        evt_valid <= 1'b1;
        evt_key   <= cur_key;
        evt_type  <= emit_type;
      end else begin
        evt_ovf <= 1'b1;
      end
    end else if (evt_ready) begin
      evt_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed table, corner-case sequences and random traffic vs a reference model.
module tb_key_event_ctrl;
  import key_evt_pkg::*;

  localparam int N = 2, CLK_DIV = 4, LONG_MS = 5, REP_MS = 3, KW = 1;

  logic          clk = 1'b0, rst = 1'b1;
  logic [N-1:0]  key_n = '1;
  logic          evt_ready = 1'b1;
  logic          evt_valid, evt_ovf, busy;
  logic [KW-1:0] evt_key;
  logic [1:0]    evt_type;

  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  key_event_ctrl #(.N(N), .CLK_DIV(CLK_DIV), .LONG_MS(LONG_MS), .REP_MS(REP_MS)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_key   (evt_key),
    .evt_type  (evt_type),
    .evt_ovf   (evt_ovf),
    .busy      (busy)
  );

  // Reference model: time in edges since reset, hold time in total ticks seen while held
  int         m_e, m_key, m_ticks, m_vkey;
  bit         m_act, m_wait, m_valid, m_ovf;
  logic [1:0] m_vtype;

  function automatic int lowest(input logic [N-1:0] k);
    for (int i = 0; i < N; i++) if (!k[i]) return i;
    return -1;
  endfunction

  function automatic bit next_is_repeat();
    return m_act && !m_wait && ((m_e % CLK_DIV) == CLK_DIV - 1) &&
           (m_ticks + 1 > LONG_MS) && (((m_ticks + 1 - LONG_MS) % REP_MS) == 0);
  endfunction

  task automatic model_reset();
    m_e = 0; m_key = 0; m_ticks = 0; m_vkey = 0; m_vtype = 2'd0;
    m_act = 0; m_wait = 0; m_valid = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] k, input logic r);
    bit t, em;
    logic [1:0] ty;
    t  = ((m_e % CLK_DIV) == CLK_DIV - 1);
    m_e++;
    em = 0; ty = 2'd0;
    if (!m_act) begin
      if (lowest(k) >= 0) begin
        m_act = 1; m_wait = 0; m_key = lowest(k); m_ticks = 0;
      end
    end else if (m_wait) begin
      if (&k) m_act = 0;
    end else if (k[m_key]) begin
      if (m_ticks < LONG_MS) begin em = 1; ty = EVT_SHORT; end
      m_wait = 1;
    end else if (t) begin
      m_ticks++;
      if (m_ticks == LONG_MS) begin em = 1; ty = EVT_LONG; end
      else if (m_ticks > LONG_MS && ((m_ticks - LONG_MS) % REP_MS) == 0) begin
        em = 1; ty = EVT_REPEAT;
      end
    end
    if (em) begin
      if (!m_valid || r) begin m_valid = 1; m_vkey = m_key; m_vtype = ty; end
      else m_ovf = 1;
    end else if (r) begin
      m_valid = 0;
    end
  endtask

  task automatic chk(input string nm, input bit ev, input int ek, input logic [1:0] et,
                     input bit eo, input bit eb);
    vecs++;
    if (evt_valid !== ev || evt_ovf !== eo || busy !== eb ||
        (ev && (evt_key !== ek[KW-1:0] || evt_type !== et))) begin
      errs++;
      $display("FAIL %s t=%0t got v=%b k=%0d ty=%0d ovf=%b busy=%b exp v=%b k=%0d ty=%0d ovf=%b busy=%b",
               nm, $time, evt_valid, evt_key, evt_type, evt_ovf, busy, ev, ek, et, eo, eb);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  // Called at a negedge; applies inputs, models the next posedge, returns at the following negedge
  task automatic step(input logic [N-1:0] k, input logic r);
    key_n = k; evt_ready = r;
    @(posedge clk);
    model_edge(k, r);
    #1;
    chk("model", m_valid, m_vkey, m_vtype, m_ovf, m_act);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    model_reset();
    repeat (cyc) begin
      @(posedge clk); #1;
      chk("reset", 0, 0, 2'd0, 0, 0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] k;
    logic         r;
    int           reps;
    bit           v;
    int           key;
    logic [1:0]   ty;
    bit           o;
    bit           b;
  } vec_t;

  vec_t tbl [14];

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, n_long, n_rep;
    bit done, r;
    logic [N-1:0] rk;

    tbl = '{
      // short press, key 0
      '{2'b10, 1'b1, 10, 0, 0, 2'd0, 0, 1},
      '{2'b11, 1'b1, 1,  1, 0, 2'd1, 0, 1},
      '{2'b11, 1'b1, 2,  0, 0, 2'd0, 0, 0},
      // simultaneous press, key 0 wins, chord suppressed
      '{2'b00, 1'b1, 5,  0, 0, 2'd0, 0, 1},
      '{2'b01, 1'b1, 1,  1, 0, 2'd1, 0, 1},
      '{2'b01, 1'b1, 40, 0, 0, 2'd0, 0, 1},
      '{2'b11, 1'b1, 1,  0, 0, 2'd0, 0, 0},
      // backpressure: second SHORT dropped, ovf sticky
      '{2'b10, 1'b0, 3,  0, 0, 2'd0, 0, 1},
      '{2'b11, 1'b0, 1,  1, 0, 2'd1, 0, 1},
      '{2'b11, 1'b0, 1,  1, 0, 2'd1, 0, 0},
      '{2'b01, 1'b0, 3,  1, 0, 2'd1, 0, 1},
      '{2'b11, 1'b0, 1,  1, 0, 2'd1, 1, 1},
      '{2'b11, 1'b1, 1,  0, 0, 2'd0, 1, 0},
      '{2'b11, 1'b1, 2,  0, 0, 2'd0, 1, 0}
    };

    @(negedge clk);
    do_reset(2);

    foreach (tbl[i]) begin
      repeat (tbl[i].reps) begin
        step(tbl[i].k, tbl[i].r);
        chk($sformatf("tbl%0d", i), tbl[i].v, tbl[i].key, tbl[i].ty, tbl[i].o, tbl[i].b);
      end
    end

    // Long press on key 1: LONG on the 5th tick, REPEAT every 3 ticks
    do_reset(2);
    first = -1; n_long = 0; n_rep = 0;
    for (int s = 1; s <= 60; s++) begin
      step(2'b01, 1'b1);
      if (evt_valid && evt_key == 1'b1 && evt_type == EVT_LONG) begin
        n_long++;
        if (first < 0) first = s;
      end
      if (evt_valid && evt_key == 1'b1 && evt_type == EVT_REPEAT) n_rep++;
    end
    chk_int("long_edge", first, 20);
    chk_int("long_cnt", n_long, 1);
    chk_int("rep_cnt", n_rep, 3);
    n = 0;
    repeat (5) begin
      step(2'b11, 1'b1);
      if (evt_valid) n++;
    end
    chk_int("release_quiet", n, 0);

    // REPEAT emitted in the very cycle the pending LONG is taken
    done = 0; n = 0;
    while (!done && n < 200) begin
      r = m_valid && next_is_repeat();
      step(2'b01, r);
      if (r) done = 1;
      n++;
    end
    chk_int("rep_xfer_seen", int'(done), 1);
    chk("rep_xfer", 1, 1, EVT_REPEAT, 0, 1);
    repeat (3) step(2'b11, 1'b1);

    // Reset while HELD at hold_ms = 3, key kept down through reset
    n = 0;
    while (m_ticks != 3 && n < 100) begin
      step(2'b10, 1'b1);
      n++;
    end
    chk_int("held3_reached", m_ticks, 3);
    do_reset(2);
    first = -1;
    for (int s = 1; s <= 40; s++) begin
      step(2'b10, 1'b1);
      if (first < 0 && evt_valid && evt_type == EVT_LONG) first = s;
    end
    chk_int("post_rst_long", first, 20);
    repeat (3) step(2'b11, 1'b1);

    // Random traffic with sticky key patterns and occasional reset
    do_reset(2);
    rk = '1;
    repeat (3000) begin
      if ($urandom_range(0, 24) == 0) rk = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 999) == 0) do_reset($urandom_range(1, 3));
      step(rk, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
